// File: rtl/seq_detect_pkg.sv
// Shared encodings for the round-robin scheduler and its bit-serial detector core.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } sched_state_t;

  function automatic det_state_t det_next(det_state_t s, logic c);
    case (s)
      S0:      return c ? S1 : S0;
      S1:      return c ? S1 : S3;
      S2:      return c ? S2 : S0;
      default: return c ? S2 : S3;
    endcase
  endfunction

endpackage

// File: rtl/seq_detect_core.sv
// Bit-serial sequence detector; Mealy output y is high when both the current
// and the next state sit in the upper half (S2/S3).
module seq_detect_core
  import seq_detect_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic c,
  output logic y
);

  det_state_t state, nxt;

  always_comb begin
    nxt = det_next(state, c);
    y   = state[1] & nxt[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= S0;
    else if (clr) state <= S0;
    else if (en)  state <= nxt;
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin front end that feeds one requester word at a time, LSB first,
// through the shared detector core and returns the hit count with the id.
module seq_detect_scheduler
  import seq_detect_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int WORD_W = 8,
  localparam int ID_W   = $clog2(N_REQ),
  localparam int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [CNT_W-1:0]        resp_hits,
  input  logic                    resp_ready
);

  localparam int             BIT_W = $clog2(WORD_W);
  localparam int             IW1   = ID_W + 1;
  localparam logic [IW1-1:0] N_EXT = IW1'(N_REQ);
  localparam logic [BIT_W-1:0] LAST = BIT_W'(WORD_W - 1);

  sched_state_t       state;
  logic [ID_W-1:0]    ptr;
  logic [WORD_W-1:0]  shreg;
  logic [BIT_W-1:0]   bit_idx;
  logic [CNT_W-1:0]   hits;
  logic               y;

  logic               found;
  logic [ID_W-1:0]    win;
  logic [IW1-1:0]     cand;
  logic               transfer;
  logic [WORD_W-1:0]  win_data;

  // Search ptr+1, ptr+2, ... wrapping once; ptr+k never exceeds 2*N_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr} + IW1'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = cand[ID_W-1:0];
      end
    end
  end

  assign transfer = (state == IDLE) && found;
  assign win_data = req_data[int'(win)*WORD_W +: WORD_W];

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[win] = 1'b1;
  end

  seq_detect_core u_core (
    .clk (clk),
    .rst (rst),
    .clr (transfer),
    .en  (state == SHIFT),
    .c   (shreg[0]),
    .y   (y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= ID_W'(N_REQ - 1);
      shreg      <= '0;
      bit_idx    <= '0;
      hits       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_hits  <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          shreg   <= win_data;
          resp_id <= win;
          ptr     <= win;
          hits    <= '0;
          bit_idx <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          shreg   <= shreg >> 1;
          hits    <= hits + CNT_W'(y);
          bit_idx <= bit_idx + 1'b1;
          // Last bit's hit is folded in here so the response is complete on entry to RESP.
          if (bit_idx == LAST) begin
            resp_hits  <= hits + CNT_W'(y);
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed plus randomized bench for seq_detect_scheduler, checked every cycle
// against a transaction-level model of the scheduler and detector.
module tb_seq_detect_scheduler;
  localparam int N_REQ = 4, WORD_W = 8, ID_W = 2, CNT_W = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid, req_ready;
  logic [N_REQ*WORD_W-1:0] req_data;
  logic                    resp_valid, resp_ready;
  logic [ID_W-1:0]         resp_id;
  logic [CNT_W-1:0]        resp_hits;

  int errors = 0, checks = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_detect_scheduler #(.N_REQ(N_REQ), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_hits(resp_hits), .resp_ready(resp_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Detector hit count from the transition table: a hit is a step that stays in {S2,S3}.
  function automatic int hits_of(input logic [WORD_W-1:0] w);
    int nxt [4][2];
    int s, h, n;
    nxt = '{'{0, 1}, '{3, 1}, '{0, 2}, '{3, 2}};
    s = 0; h = 0;
    for (int k = 0; k < WORD_W; k++) begin
      n = nxt[s][w[k]];
      if (s >= 2 && n >= 2) h++;
      s = n;
    end
    return h;
  endfunction

  // Model: m_phase -1 idle, 0..WORD_W-1 bits in flight, WORD_W response held.
  int m_phase = -1, m_ptr = N_REQ - 1, m_id = 0, m_hits = 0;
  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_rdy;
    int w;
    if (rst) begin
      m_phase = -1;
      m_ptr   = N_REQ - 1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_hits", resp_hits, 0);
    end else begin
      exp_rdy = '0;
      w = -1;
      if (m_phase < 0)
        for (int k = 1; k <= N_REQ; k++)
          if (w < 0 && req_valid[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("resp_valid", resp_valid, m_phase == WORD_W);
      if (m_phase == WORD_W) begin
        chk("resp_id", resp_id, m_id);
        chk("resp_hits", resp_hits, m_hits);
      end
      if (w >= 0) begin
        m_id = w; m_ptr = w; m_phase = 0;
        m_hits = hits_of(req_data[w*WORD_W +: WORD_W]);
      end else if (m_phase >= 0 && m_phase < WORD_W) m_phase++;
      else if (m_phase == WORD_W && resp_ready) m_phase = -1;
    end
  end

  task automatic wait_any_grant(output int idx, output int gcyc);
    int n = 0;
    @(negedge clk);
    while ((req_valid & req_ready) == '0 && n < 60) begin @(negedge clk); n++; end
    chk("grant_timeout", n < 60, 1);
    idx = -1;
    for (int i = 0; i < N_REQ; i++) if (req_valid[i] & req_ready[i]) idx = i;
    gcyc = cyc;
  endtask

  task automatic wait_resp(output int rcyc);
    int n = 0;
    @(negedge clk);
    while (!resp_valid && n < 60) begin @(negedge clk); n++; end
    chk("resp_timeout", n < 60, 1);
    rcyc = cyc;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_one(input int i, input logic [WORD_W-1:0] w, input int exp_hits);
    int idx, g, r;
    req_data[i*WORD_W +: WORD_W] = w;
    req_valid[i] = 1'b1;
    wait_any_grant(idx, g);
    chk("one_grant_id", idx, i);
    @(posedge clk); #1 req_valid[i] = 1'b0;
    wait_resp(r);
    chk("one_latency", r - g, WORD_W + 1);
    chk("one_id", resp_id, i);
    chk("one_hits", resp_hits, exp_hits);
  endtask

  initial begin
    int idx, g, r, prev, a;
    logic [WORD_W-1:0] words [3];
    int exp3 [3];
    logic [N_REQ-1:0] gr;

    rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b1;

    // Pin the model's detector to hand-worked words.
    chk("model_02", hits_of(8'h02), 5);
    chk("model_FF", hits_of(8'hFF), 0);
    chk("model_06", hits_of(8'h06), 4);
    chk("model_F2", hits_of(8'hF2), 5);
    chk("model_12", hits_of(8'h12), 2);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 4'b0000);

    // Requester 0, word 0x02: one-cycle grant, response nine cycles on.
    @(posedge clk); #1;
    req_data[0 +: WORD_W] = 8'h02; req_valid = 4'b0001;
    wait_any_grant(idx, g);
    chk("t1_ready", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("t1_ready_drop", req_ready, 4'b0000);
    wait_resp(r);
    chk("t1_latency", r - g, 9);
    chk("t1_id", resp_id, 0);
    chk("t1_hits", resp_hits, 5);

    // Requester 1 held valid, data advanced on each grant: period WORD_W+2.
    words = '{8'hFF, 8'h00, 8'h06};
    exp3  = '{0, 0, 4};
    @(posedge clk); #1;
    req_data[WORD_W +: WORD_W] = words[0]; req_valid[1] = 1'b1;
    prev = 0;
    for (int j = 0; j < 3; j++) begin
      wait_any_grant(idx, g);
      chk("t2_id", idx, 1);
      if (j > 0) chk("t2_period", g - prev, WORD_W + 2);
      prev = g;
      @(posedge clk); #1;
      if (j < 2) req_data[WORD_W +: WORD_W] = words[j+1];
      else req_valid[1] = 1'b0;
      wait_resp(r);
      chk("t2_hits", resp_hits, exp3[j]);
    end

    run_one(2, 8'hF2, 5);
    run_one(2, 8'h12, 2);

    // All four valid: strict rotation from requester 0.
    do_reset();
    req_data = 32'h44332211; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_any_grant(idx, g);
      chk("t4_order", idx, k % N_REQ);
      wait_resp(r);
      chk("t4_resp_id", resp_id, k % N_REQ);
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (12) @(posedge clk);

    // Stalled response: outputs hold, no grants, next grant right after accept.
    #1 resp_ready = 1'b0; req_valid = 4'b0011; req_data = 32'h0000A512;
    wait_any_grant(idx, g);
    wait_resp(r);
    prev = resp_hits; a = resp_id;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_valid", resp_valid, 1);
      chk("t5_id", resp_id, a);
      chk("t5_hits", resp_hits, prev);
      chk("t5_ready", req_ready, 4'b0000);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk); a = cyc;
    wait_any_grant(idx, g);
    chk("t5_next_grant", g - a, 1);
    @(posedge clk); #1 req_valid = '0;
    wait_resp(r);

    // Reset during SHIFT bit 3: word dropped, requester 0 first afterwards.
    @(posedge clk); #1 req_valid = 4'b0100; req_data = 32'h00F20000;
    wait_any_grant(idx, g);
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_valid", resp_valid, 0);
    chk("t6_id", resp_id, 0);
    chk("t6_hits", resp_hits, 0);
    chk("t6_ready", req_ready, 4'b0000);
    @(posedge clk); #1 rst = 1'b0; req_valid = 4'b1111;
    wait_any_grant(idx, g);
    chk("t6_first_grant", idx, 0);
    @(posedge clk); #1 req_valid = '0;
    wait_resp(r);

    // Randomized traffic with withdrawals, back-pressure and occasional resets.
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk); gr = req_valid & req_ready;
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(599) == 0) rst = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (gr[i]) begin
          req_valid[i] = ($urandom_range(1) == 1);
          req_data[i*WORD_W +: WORD_W] = WORD_W'($urandom);
        end else if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*WORD_W +: WORD_W] = WORD_W'($urandom);
        end else if (req_valid[i] && $urandom_range(29) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(2) != 0);
    end
    @(posedge clk); #1 rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
    repeat (15) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
